bp_update_ctrl: RTL



---
 rtl/bp_update_ctrl_if.sv | 33 +++
 rtl/bp_update_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl_if.sv
// Retirement-side update bundle for the branch predictor counter writer.
// Two lanes per cycle, lane 0 older; ready gates both lanes together.
interface bp_update_ctrl_if #(
  parameter int INDEX = 6
);
  logic             upd0_valid_i;
  logic [INDEX-1:0] upd0_index_i;
  logic             upd0_taken_i;
  logic             upd1_valid_i;
  logic [INDEX-1:0] upd1_index_i;
  logic             upd1_taken_i;
  logic             upd_ready_o;

  modport master (
    output upd0_valid_i,
    output upd0_index_i,
    output upd0_taken_i,
    output upd1_valid_i,
    output upd1_index_i,
    output upd1_taken_i,
    input  upd_ready_o
  );

  modport slave (
    input  upd0_valid_i,
    input  upd0_index_i,
    input  upd0_taken_i,
    input  upd1_valid_i,
    input  upd1_index_i,
    input  upd1_taken_i,
    output upd_ready_o
  );
endinterface

// File: rtl/bp_update_ctrl.sv
// Commit-side branch predictor counter writer: dual-lane queue feeding
// a read / write saturating-counter pipeline with W->R forwarding.
module bp_update_ctrl #(
  parameter int INDEX      = 6,
  parameter int CTR_BITS   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  bp_update_ctrl_if.slave     upd,
  output logic [INDEX-1:0]    ram_rd_addr_o,
  input  logic [CTR_BITS-1:0] ram_rd_data_i,
  output logic [INDEX-1:0]    ram_wr_addr_o,
  output logic [CTR_BITS-1:0] ram_wr_data_o,
  output logic                ram_we_o,
  output logic                busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef struct packed {
    logic [INDEX-1:0] idx;
    logic             taken;
  } upd_t;

  upd_t                r_q [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [PW:0]         r_count;

  logic                r_w_valid;
  logic [INDEX-1:0]    r_w_idx;
  logic [CTR_BITS-1:0] r_w_data;

  logic [PW:0]         w_free;
  logic                w_ready;
  logic                w_push0;
  logic                w_push1;
  logic                w_pop;
  logic [PW-1:0]       w_wptr1;
  upd_t                w_lane0;
  upd_t                w_lane1;
  upd_t                w_head;
  logic                w_r_valid;
  logic                w_fwd;
  logic [CTR_BITS-1:0] w_old;
  logic [CTR_BITS-1:0] w_new;

  assign w_free  = DEPTH_C - r_count;
  assign w_ready = (w_free >= (PW+1)'(2)) && !reset;
  assign w_push0 = upd.upd0_valid_i && w_ready;
  assign w_push1 = upd.upd1_valid_i && w_ready;
  assign w_pop   = (r_count != '0);
  assign w_wptr1 = r_wptr + PW'(w_push0);

  assign w_lane0 = '{idx: upd.upd0_index_i, taken: upd.upd0_taken_i};
  assign w_lane1 = '{idx: upd.upd1_index_i, taken: upd.upd1_taken_i};

  assign upd.upd_ready_o = w_ready;

  // Stage R is the queue head itself; it retires into W every cycle.
  assign w_head    = r_q[r_rptr];
  assign w_r_valid = w_pop;
  assign w_fwd     = r_w_valid && (r_w_idx == w_head.idx);
  assign w_old     = w_fwd ? r_w_data : ram_rd_data_i;

  always_comb begin
    w_new = w_old;
    if (w_head.taken) begin
      if (w_old != CTR_MAX)
        w_new = w_old + CTR_BITS'(1);
    end else begin
      if (w_old != '0)
        w_new = w_old - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push0)
      r_q[r_wptr] <= w_lane0;
    if (w_push1)
      r_q[w_wptr1] <= w_lane1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr1 + PW'(w_push1);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count
               + (PW+1)'(w_push0)
               + (PW+1)'(w_push1)
               - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_valid <= 1'b0;
      r_w_idx   <= '0;
      r_w_data  <= '0;
    end else begin
      r_w_valid <= w_r_valid;
      if (w_r_valid) begin
        r_w_idx  <= w_head.idx;
        r_w_data <= w_new;
      end
    end
  end

  assign ram_rd_addr_o = (w_r_valid && !reset) ? w_head.idx : '0;
  assign ram_we_o      = r_w_valid && !reset;
  assign ram_wr_addr_o = reset ? '0 : r_w_idx;
  assign ram_wr_data_o = reset ? '0 : r_w_data;
  assign busy_o        = !reset && (w_r_valid || r_w_valid);

endmodule
